rv_writeback_unit: RTL and testbench

Writeback stage driving the register file write port (we / rd / wdata) and answering the decode stage's operand-hazard queries. Merges single-cycle ALU results with in-order, variable-latency load responses, and tracks outstanding load destinations in a scoreboard. Every register-file write passes through one registered output stage. Sits between the execute/LSU stages and the 32 x 32 register file, whose writes commit on posedge clk and whose x0 reads as zero.

---
 rtl/rv_writeback_unit_pkg.sv | 14 +
 rtl/rv_writeback_unit_if.sv | 58 +++++
 rtl/rv_writeback_unit_tag_fifo.sv | 42 ++++
 rtl/rv_writeback_unit.sv | 98 +++++++++
 tb/tb_rv_writeback_unit.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_writeback_unit_pkg.sv
// Shared constants and types for the writeback stage (package rv_wb_pkg).
// Forwarding outputs are enabled by defining RV_WB_FWD_EN.
package rv_wb_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LOAD
    } wb_src_e;

endpackage

// File: rtl/rv_writeback_unit_if.sv
// Handshake/bus bundle between execute/LSU/decode and the writeback stage.
// RV_WB_FWD_EN adds the per-source forwarding signals.
interface rv_writeback_unit_if
    import rv_wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;

    logic                  ld_issue_valid;
    logic                  ld_issue_ready;
    logic [REG_ADDR_W-1:0] ld_issue_rd;
    logic                  ld_resp_valid;
    logic [XLEN-1:0]       ld_resp_data;

    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs1_busy;
    logic                  rs2_busy;

    logic                  reg_we;
    logic [REG_ADDR_W-1:0] reg_rd;
    logic [XLEN-1:0]       reg_wdata;
    wb_src_e               wb_src;

`ifdef RV_WB_FWD_EN
    logic                  rs1_fwd_valid;
    logic                  rs2_fwd_valid;
    logic [XLEN-1:0]       rs1_fwd_data;
    logic [XLEN-1:0]       rs2_fwd_data;
`endif

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue_valid, ld_issue_rd, ld_resp_valid, ld_resp_data,
        input  rs1, rs2,
        output alu_ready, ld_issue_ready, rs1_busy, rs2_busy,
        output reg_we, reg_rd, reg_wdata, wb_src
`ifdef RV_WB_FWD_EN
        , output rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data
`endif
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue_valid, ld_issue_rd, ld_resp_valid, ld_resp_data,
        output rs1, rs2,
        input  alu_ready, ld_issue_ready, rs1_busy, rs2_busy,
        input  reg_we, reg_rd, reg_wdata, wb_src
`ifdef RV_WB_FWD_EN
        , input rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data
`endif
    );

endinterface

// File: rtl/rv_writeback_unit_tag_fifo.sv
// Synchronous tag FIFO holding destination registers of outstanding loads.
// Pointers carry an extra wrap bit to tell full from empty.
module rv_wb_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o  = mem_q[rptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/rv_writeback_unit.sv
// Writeback stage: load/ALU write arbitration, load scoreboard and hazard outputs.
// RV_WB_FWD_EN replaces the in-flight stall term with forwarding outputs.
module rv_writeback_unit
    import rv_wb_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int LD_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    rv_writeback_unit_if.slave wb
);
    logic [31:0]           pending_q, pending_d;
    logic                  fifo_full, fifo_empty;
    logic [REG_ADDR_W-1:0] head_rd;
    logic                  ld_issue_ready, alu_ready;
    logic                  ld_push, ld_pop, alu_fire;

    logic                  we_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       wdata_q;
    wb_src_e               src_q;

    // The pending check forbids set-and-clear of one register in a single cycle.
    assign ld_issue_ready = !fifo_full && !pending_q[wb.ld_issue_rd];
    assign alu_ready      = !wb.ld_resp_valid && !pending_q[wb.alu_rd];
    assign ld_push        = wb.ld_issue_valid && ld_issue_ready;
    assign ld_pop         = wb.ld_resp_valid && !fifo_empty;
    assign alu_fire       = wb.alu_valid && alu_ready;

    rv_wb_tag_fifo #(
        .DEPTH (LD_DEPTH),
        .WIDTH (REG_ADDR_W)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ld_push),
        .wdata_i (wb.ld_issue_rd),
        .pop_i   (ld_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head_rd)
    );

    always_comb begin
        pending_d = pending_q;
        if (ld_pop)  pending_d[head_rd]        = 1'b0;
        if (ld_push) pending_d[wb.ld_issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            wdata_q   <= '0;
            src_q     <= WB_NONE;
        end else begin
            pending_q <= pending_d;
            if (ld_pop) begin
                we_q    <= (head_rd != '0);
                rd_q    <= head_rd;
                wdata_q <= wb.ld_resp_data;
                src_q   <= (head_rd != '0) ? WB_LOAD : WB_NONE;
            end else if (alu_fire) begin
                we_q    <= (wb.alu_rd != '0);
                rd_q    <= wb.alu_rd;
                wdata_q <= wb.alu_data;
                src_q   <= (wb.alu_rd != '0) ? WB_ALU : WB_NONE;
            end else begin
                we_q  <= 1'b0;
                src_q <= WB_NONE;
            end
        end
    end

    assign wb.ld_issue_ready = ld_issue_ready;
    assign wb.alu_ready      = alu_ready;
    assign wb.reg_we         = we_q;
    assign wb.reg_rd         = rd_q;
    assign wb.reg_wdata      = wdata_q;
    assign wb.wb_src         = src_q;

`ifdef RV_WB_FWD_EN
    assign wb.rs1_fwd_valid = we_q && (rd_q == wb.rs1) && (wb.rs1 != '0);
    assign wb.rs2_fwd_valid = we_q && (rd_q == wb.rs2) && (wb.rs2 != '0);
    assign wb.rs1_fwd_data  = wdata_q;
    assign wb.rs2_fwd_data  = wdata_q;
    assign wb.rs1_busy      = pending_q[wb.rs1];
    assign wb.rs2_busy      = pending_q[wb.rs2];
`else
    // Without forwarding, a source must also wait out the cycle its write is in flight.
    assign wb.rs1_busy = pending_q[wb.rs1] || (we_q && (rd_q == wb.rs1) && (wb.rs1 != '0));
    assign wb.rs2_busy = pending_q[wb.rs2] || (we_q && (rd_q == wb.rs2) && (wb.rs2 != '0));
`endif

endmodule

// File: tb/tb_rv_writeback_unit.sv
// Directed self-checking bench for rv_writeback_unit (both RV_WB_FWD_EN builds).
module tb_rv_writeback_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rv_writeback_unit_if #(.XLEN(32)) wb ();

    rv_writeback_unit #(.XLEN(32), .LD_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wb.alu_valid      = 1'b0;
        wb.alu_rd         = '0;
        wb.alu_data       = '0;
        wb.ld_issue_valid = 1'b0;
        wb.ld_issue_rd    = '0;
        wb.ld_resp_valid  = 1'b0;
        wb.ld_resp_data   = '0;
        wb.rs1            = '0;
        wb.rs2            = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (wb.reg_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", wb.reg_we); end
        checks++; if (wb.reg_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", wb.reg_rd); end
        checks++; if (wb.reg_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", wb.reg_wdata); end
        checks++; if (wb.ld_issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %b want 1", wb.ld_issue_ready); end
        checks++; if (wb.alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %b want 1", wb.alu_ready); end
        wb.ld_resp_valid = 1'b1;
        wb.ld_resp_data  = 32'h0BAD;
        #1;
        checks++; if (wb.alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready_resp: got %b want 0", wb.alu_ready); end
        tick();
        wb.ld_resp_valid = 1'b0;
        checks++; if (wb.reg_we !== 1'b0) begin errors++; $display("FAIL empty_resp_we: got %b want 0", wb.reg_we); end
    endtask

    task automatic test_alu();
        wb.alu_valid = 1'b1;
        wb.alu_rd    = 5'd5;
        wb.alu_data  = 32'h1234;
        #1;
        checks++; if (wb.alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %b want 1", wb.alu_ready); end
        tick();
        wb.alu_rd   = 5'd0;
        wb.alu_data = 32'h0099;
        checks++; if (wb.reg_we !== 1'b1) begin errors++; $display("FAIL alu_we: got %b want 1", wb.reg_we); end
        checks++; if (wb.reg_rd !== 5'd5) begin errors++; $display("FAIL alu_rd: got %0d want 5", wb.reg_rd); end
        checks++; if (wb.reg_wdata !== 32'h1234) begin errors++; $display("FAIL alu_wdata: got %h want 1234", wb.reg_wdata); end
        tick();
        wb.alu_valid = 1'b0;
        checks++; if (wb.reg_we !== 1'b0) begin errors++; $display("FAIL alu_x0_we: got %b want 0", wb.reg_we); end
        tick();
        checks++; if (wb.reg_we !== 1'b0) begin errors++; $display("FAIL idle_we: got %b want 0", wb.reg_we); end
        checks++; if (wb.reg_wdata !== 32'h0099) begin errors++; $display("FAIL idle_hold_wdata: got %h want 99", wb.reg_wdata); end
    endtask

    task automatic test_load();
        wb.ld_issue_valid = 1'b1;
        wb.ld_issue_rd    = 5'd7;
        #1;
        checks++; if (wb.ld_issue_ready !== 1'b1) begin errors++; $display("FAIL load_issue_ready: got %b want 1", wb.ld_issue_ready); end
        tick();
        wb.ld_issue_valid = 1'b0;
        wb.rs1            = 5'd7;
        wb.alu_valid      = 1'b1;
        wb.alu_rd         = 5'd7;
        wb.alu_data       = 32'h7777;
        #1;
        checks++; if (wb.rs1_busy !== 1'b1) begin errors++; $display("FAIL load_busy_set: got %b want 1", wb.rs1_busy); end
        checks++; if (wb.alu_ready !== 1'b0) begin errors++; $display("FAIL load_waw_block: got %b want 0", wb.alu_ready); end
        tick();
        wb.alu_valid = 1'b0;
        checks++; if (wb.reg_we !== 1'b0) begin errors++; $display("FAIL load_waw_no_write: got %b want 0", wb.reg_we); end
        tick();
        checks++; if (wb.rs1_busy !== 1'b1) begin errors++; $display("FAIL load_busy_hold: got %b want 1", wb.rs1_busy); end
        wb.ld_resp_valid = 1'b1;
        wb.ld_resp_data  = 32'hCAFE;
        tick();
        wb.ld_resp_valid = 1'b0;
        #1;
        checks++; if (wb.reg_we !== 1'b1) begin errors++; $display("FAIL load_we: got %b want 1", wb.reg_we); end
        checks++; if (wb.reg_rd !== 5'd7) begin errors++; $display("FAIL load_rd: got %0d want 7", wb.reg_rd); end
        checks++; if (wb.reg_wdata !== 32'hCAFE) begin errors++; $display("FAIL load_wdata: got %h want cafe", wb.reg_wdata); end
`ifdef RV_WB_FWD_EN
        checks++; if (wb.rs1_busy !== 1'b0) begin errors++; $display("FAIL load_busy_inflight: got %b want 0", wb.rs1_busy); end
`else
        checks++; if (wb.rs1_busy !== 1'b1) begin errors++; $display("FAIL load_busy_inflight: got %b want 1", wb.rs1_busy); end
`endif
        tick();
        checks++; if (wb.rs1_busy !== 1'b0) begin errors++; $display("FAIL load_busy_clear: got %b want 0", wb.rs1_busy); end
        wb.rs1 = 5'd0;
    endtask

    task automatic test_collide();
        wb.ld_issue_valid = 1'b1;
        wb.ld_issue_rd    = 5'd3;
        tick();
        wb.ld_issue_valid = 1'b0;
        wb.ld_resp_valid  = 1'b1;
        wb.ld_resp_data   = 32'hAAAA;
        wb.alu_valid      = 1'b1;
        wb.alu_rd         = 5'd4;
        wb.alu_data       = 32'hBBBB;
        #1;
        checks++; if (wb.alu_ready !== 1'b0) begin errors++; $display("FAIL collide_alu_ready: got %b want 0", wb.alu_ready); end
        tick();
        wb.ld_resp_valid = 1'b0;
        #1;
        checks++; if (wb.reg_rd !== 5'd3 || wb.reg_wdata !== 32'hAAAA || wb.reg_we !== 1'b1) begin
            errors++; $display("FAIL collide_load: got we=%b rd=%0d data=%h want we=1 rd=3 data=aaaa", wb.reg_we, wb.reg_rd, wb.reg_wdata); end
        checks++; if (wb.alu_ready !== 1'b1) begin errors++; $display("FAIL collide_alu_ready2: got %b want 1", wb.alu_ready); end
        tick();
        wb.alu_valid = 1'b0;
        checks++; if (wb.reg_rd !== 5'd4 || wb.reg_wdata !== 32'hBBBB || wb.reg_we !== 1'b1) begin
            errors++; $display("FAIL collide_alu: got we=%b rd=%0d data=%h want we=1 rd=4 data=bbbb", wb.reg_we, wb.reg_rd, wb.reg_wdata); end
        tick();
    endtask

    task automatic test_full();
        logic [31:0] exp_data;
        for (int r = 1; r <= 4; r++) begin
            wb.ld_issue_valid = 1'b1;
            wb.ld_issue_rd    = 5'(r);
            #1;
            checks++; if (wb.ld_issue_ready !== 1'b1) begin errors++; $display("FAIL full_issue_ready_%0d: got %b want 1", r, wb.ld_issue_ready); end
            tick();
            if (r == 1) begin
                wb.ld_issue_rd = 5'd1;
                #1;
                checks++; if (wb.ld_issue_ready !== 1'b0) begin errors++; $display("FAIL full_reissue_pending: got %b want 0", wb.ld_issue_ready); end
            end
        end
        wb.ld_issue_rd = 5'd5;
        wb.rs2         = 5'd3;
        #1;
        checks++; if (wb.ld_issue_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", wb.ld_issue_ready); end
        checks++; if (wb.rs2_busy !== 1'b1) begin errors++; $display("FAIL full_rs2_busy: got %b want 1", wb.rs2_busy); end
        wb.ld_resp_valid = 1'b1;
        wb.ld_resp_data  = 32'h11;
        #1;
        checks++; if (wb.ld_issue_ready !== 1'b0) begin errors++; $display("FAIL full_pop_push_block: got %b want 0", wb.ld_issue_ready); end
        for (int r = 1; r <= 4; r++) begin
            tick();
            wb.ld_issue_valid = 1'b0;
            exp_data = 32'(r * 17);
            checks++; if (wb.reg_we !== 1'b1 || wb.reg_rd !== 5'(r) || wb.reg_wdata !== exp_data) begin
                errors++; $display("FAIL full_resp_%0d: got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h", r, wb.reg_we, wb.reg_rd, wb.reg_wdata, r, exp_data); end
            wb.ld_resp_data = 32'((r + 1) * 17);
            if (r == 4) wb.ld_resp_valid = 1'b0;
        end
        wb.ld_issue_rd = 5'd1;
        wb.rs2         = 5'd0;
        tick();
        checks++; if (wb.ld_issue_ready !== 1'b1) begin errors++; $display("FAIL full_drained_ready: got %b want 1", wb.ld_issue_ready); end
        checks++; if (wb.reg_we !== 1'b0) begin errors++; $display("FAIL full_extra_write: got %b want 0", wb.reg_we); end
    endtask

    task automatic test_rd0_load();
        wb.ld_issue_valid = 1'b1;
        wb.ld_issue_rd    = 5'd0;
        wb.rs1            = 5'd0;
        #1;
        checks++; if (wb.ld_issue_ready !== 1'b1) begin errors++; $display("FAIL rd0_issue_ready: got %b want 1", wb.ld_issue_ready); end
        tick();
        wb.ld_issue_valid = 1'b0;
        checks++; if (wb.rs1_busy !== 1'b0) begin errors++; $display("FAIL rd0_busy: got %b want 0", wb.rs1_busy); end
        wb.ld_resp_valid = 1'b1;
        wb.ld_resp_data  = 32'hDEAD;
        tick();
        wb.ld_resp_valid  = 1'b0;
        checks++; if (wb.reg_we !== 1'b0) begin errors++; $display("FAIL rd0_resp_we: got %b want 0", wb.reg_we); end
        wb.ld_issue_valid = 1'b1;
        wb.ld_issue_rd    = 5'd2;
        tick();
        wb.ld_issue_valid = 1'b0;
        wb.ld_resp_valid  = 1'b1;
        wb.ld_resp_data   = 32'h22;
        tick();
        wb.ld_resp_valid = 1'b0;
        checks++; if (wb.reg_we !== 1'b1 || wb.reg_rd !== 5'd2 || wb.reg_wdata !== 32'h22) begin
            errors++; $display("FAIL rd0_next_load: got we=%b rd=%0d data=%h want we=1 rd=2 data=22", wb.reg_we, wb.reg_rd, wb.reg_wdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int r = 1; r <= 3; r++) begin
            wb.ld_issue_valid = 1'b1;
            wb.ld_issue_rd    = 5'(r);
            tick();
        end
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wb.ld_issue_rd = 5'd1;
        wb.rs1         = 5'd1;
        wb.rs2         = 5'd2;
        #1;
        checks++; if (wb.ld_issue_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", wb.ld_issue_ready); end
        checks++; if (wb.rs1_busy !== 1'b0 || wb.rs2_busy !== 1'b0) begin
            errors++; $display("FAIL midrst_busy: got %b%b want 00", wb.rs1_busy, wb.rs2_busy); end
        wb.ld_resp_valid = 1'b1;
        wb.ld_resp_data  = 32'h0BAD;
        tick();
        wb.ld_resp_valid = 1'b0;
        checks++; if (wb.reg_we !== 1'b0 || wb.reg_rd !== 5'd0) begin
            errors++; $display("FAIL midrst_stale: got we=%b rd=%0d want we=0 rd=0", wb.reg_we, wb.reg_rd); end
        clear_inputs();
    endtask

    task automatic test_fwd();
        wb.alu_valid = 1'b1;
        wb.alu_rd    = 5'd9;
        wb.alu_data  = 32'h55;
        tick();
        wb.alu_valid = 1'b0;
        wb.rs2       = 5'd9;
        #1;
`ifdef RV_WB_FWD_EN
        checks++; if (wb.rs2_fwd_valid !== 1'b1 || wb.rs2_fwd_data !== 32'h55) begin
            errors++; $display("FAIL fwd_rs2: got valid=%b data=%h want valid=1 data=55", wb.rs2_fwd_valid, wb.rs2_fwd_data); end
        checks++; if (wb.rs2_busy !== 1'b0) begin errors++; $display("FAIL fwd_busy: got %b want 0", wb.rs2_busy); end
`else
        checks++; if (wb.rs2_busy !== 1'b1) begin errors++; $display("FAIL fwd_busy: got %b want 1", wb.rs2_busy); end
`endif
        wb.rs2 = 5'd0;
        #1;
        checks++; if (wb.rs2_busy !== 1'b0) begin errors++; $display("FAIL fwd_busy_x0: got %b want 0", wb.rs2_busy); end
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_alu();
        test_load();
        test_collide();
        test_full();
        test_rd0_load();
        test_reset_mid();
        test_fwd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
